// File: rtl/cplx_frame_feeder_if.sv
// Load and replay ports of the frame feeder: valid/ready load side plus the
// accumulator-facing input_YV / sel_sum_cycle side.
interface cplx_frame_feeder_if #(
    parameter int WIDTH = 48
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_YV;
    logic             out_valid;
    logic             sel_sum_cycle;

    modport master (
        output in_data, in_valid,
        input  in_ready, out_YV, out_valid, sel_sum_cycle
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_YV, out_valid, sel_sum_cycle
    );
endinterface

// File: rtl/cplx_frame_feeder.sv
// Buffers one frame of packed complex samples, replays it to the accumulator
// (optionally conjugated) and trails it with a zero flush.
//
// state  | meaning
// IDLE   | waiting for start; illegal frame_len pulses err
// LOAD   | in_ready high, filling mem_q[0..len-1]
// STREAM | one word per cycle to out_YV, sel_sum_cycle on word 0
// FLUSH  | FLUSH_LEN zero cycles, then done with return to IDLE
module cplx_frame_feeder #(
    parameter int WIDTH     = 48,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int FLUSH_LEN = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [AW:0]         frame_len,
    input  logic                conj_en,
    cplx_frame_feeder_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int HW  = WIDTH / 2;
    localparam int FCW = $clog2(FLUSH_LEN + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] FLUSH  = 2'd3;

    localparam logic [AW:0]    DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [FCW-1:0] FL_LAST = FCW'(FLUSH_LEN - 1);
    localparam logic [HW-1:0]  IM_MIN  = {1'b1, {(HW - 1){1'b0}}};
    localparam logic [HW-1:0]  IM_MAX  = {1'b0, {(HW - 1){1'b1}}};

    logic [1:0]       state_q, state_d;
    logic [AW:0]      len_q, len_d;
    logic             conj_q, conj_d;
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;
    logic [WIDTH-1:0] yv_q, yv_d;
    logic             valid_q, valid_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             wr_en;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Saturating negate: the most negative imag has no positive twin.
    function automatic logic [WIDTH-1:0] replay_word(input logic [WIDTH-1:0] w, input logic cj);
        logic [HW-1:0] im;
        im = w[HW-1:0];
        if (cj) begin
            im = (im == IM_MIN) ? IM_MAX : (~im + 1'b1);
        end
        return {w[WIDTH-1:HW], im};
    endfunction

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        conj_d  = conj_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        fcnt_d  = fcnt_q;
        yv_d    = '0;
        valid_d = 1'b0;
        sel_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_len != '0 && frame_len <= DEPTH_W) begin
                        len_d   = frame_len;
                        conj_d  = conj_en;
                        wptr_d  = '0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.in_valid && ready_q) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    if (wptr_q == len_q - 1'b1) begin
                        // A one-word frame has word 0 still on in_data this cycle.
                        yv_d    = replay_word((wptr_q == '0) ? bus.in_data : mem_q[0], conj_q);
                        valid_d = 1'b1;
                        sel_d   = 1'b1;
                        rptr_d  = (AW + 1)'(1);
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (rptr_q == len_q) begin
                    fcnt_d  = FL_LAST;
                    state_d = FLUSH;
                end else begin
                    yv_d    = replay_word(mem_q[rptr_q[AW-1:0]], conj_q);
                    valid_d = 1'b1;
                    rptr_d  = rptr_q + 1'b1;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            conj_q  <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fcnt_q  <= '0;
            yv_q    <= '0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            conj_q  <= conj_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fcnt_q  <= fcnt_d;
            yv_q    <= yv_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready      = ready_q;
    assign bus.out_YV        = yv_q;
    assign bus.out_valid     = valid_q;
    assign bus.sel_sum_cycle = sel_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
endmodule

// File: tb/tb_cplx_frame_feeder.sv
// Randomized scoreboard bench for cplx_frame_feeder: stimulus pushes expected
// replay words, a negedge monitor pops and compares them.
module tb_cplx_frame_feeder;
    localparam int W  = 48;
    localparam int AW = 4;

    typedef struct {
        logic [W-1:0] word;
        logic         sel;
        logic         last;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          start;
    logic [AW:0]   frame_len;
    logic          conj_en;
    logic          busy, done, err;

    cplx_frame_feeder_if #(.WIDTH(W)) bus ();

    cplx_frame_feeder #(.WIDTH(W), .DEPTH(16), .AW(AW), .FLUSH_LEN(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .frame_len (frame_len),
        .conj_en   (conj_en),
        .bus       (bus.slave),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         exp_q[$];
    logic [W-1:0] src_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Reference conjugate with plain integer arithmetic, clipped to the positive range.
    function automatic logic [W-1:0] model_word(input logic [W-1:0] w, input bit cj);
        int im;
        int nim;
        im = $signed(w[23:0]);
        if (!cj) return w;
        nim = -im;
        if (nim > 8388607) nim = 8388607;
        return {w[47:24], nim[23:0]};
    endfunction

    // Monitor: pops one expectation per valid word, tracks flush gap and done timing.
    initial begin
        int  done_cd;
        int  idle_run;
        bit  first_frame;
        bit  exp_done;
        exp_t e;
        done_cd = -1;
        idle_run = 0;
        first_frame = 1'b1;
        forever begin
            @(negedge clock);
            if (!reset) begin
                exp_q.delete();
                done_cd = -1;
                idle_run = 0;
                first_frame = 1'b1;
            end else begin
                if (done_cd > 0) done_cd--;
                exp_done = (done_cd == 0);
                if (done || exp_done) check("done_timing", 64'(done), 64'(exp_done));
                if (done_cd == 0) done_cd = -1;
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 64'(bus.out_YV), 64'h0);
                        check("unexpected_valid", 64'(bus.out_valid), 64'h0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_YV", 64'(bus.out_YV), 64'(e.word));
                        check("sel_sum_cycle", 64'(bus.sel_sum_cycle), 64'(e.sel));
                        if (e.sel && !first_frame) check("frame_gap_ge3", 64'(idle_run >= 3), 64'h1);
                        if (e.sel) first_frame = 1'b0;
                        if (e.last) done_cd = 4;
                    end
                    idle_run = 0;
                end else begin
                    check("idle_zero", {15'h0, bus.sel_sum_cycle, bus.out_YV}, 64'h0);
                    idle_run++;
                end
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic start_frame(input int len, input bit cj);
        start = 1'b1;
        frame_len = (AW + 1)'(len);
        conj_en = cj;
        @(posedge clock); #1;
        start = 1'b0;
        check("load_ready", 64'(bus.in_ready), 64'h1);
        check("load_busy", 64'(busy), 64'h1);
    endtask

    // mode 0: in_valid always, 1: toggling 1,0,.., 2: random
    task automatic load_words(input int len, input bit cj, input int mode);
        int idx;
        int cyc;
        bit v;
        logic [W-1:0] w;
        exp_t e;
        idx = 0;
        cyc = 0;
        while (idx < len && cyc < 400) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            if (v && src_q.size() > 0) w = src_q.pop_front();
            else w = W'({$urandom(), $urandom()});
            bus.in_valid = v;
            bus.in_data = w;
            check("in_ready_load", 64'(bus.in_ready), 64'h1);
            @(posedge clock);
            if (v) begin
                e.word = model_word(w, cj);
                e.sel = (idx == 0);
                e.last = (idx == len - 1);
                exp_q.push_back(e);
                idx++;
            end
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("load_complete", 64'(idx), 64'(len));
        check("ready_drop", 64'(bus.in_ready), 64'h0);
        check("first_word_latency", 64'(bus.out_valid), 64'h1);
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("done_seen", 64'(done), 64'h1);
    endtask

    task automatic bad_start(input int len);
        start = 1'b1;
        frame_len = (AW + 1)'(len);
        @(posedge clock); #1;
        start = 1'b0;
        check("err_pulse", 64'(err), 64'h1);
        check("err_busy", 64'(busy), 64'h0);
        check("err_ready", 64'(bus.in_ready), 64'h0);
        @(posedge clock); #1;
        check("err_clear", 64'(err), 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int n_valid;
        reset = 1'b0;
        start = 1'b0;
        frame_len = '0;
        conj_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        #12;
        check("reset_outputs", {57'h0, busy, done, err, bus.in_ready,
              bus.out_valid, bus.sel_sum_cycle, 1'b0}, 64'h0);
        check("reset_yv", 64'(bus.out_YV), 64'h0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        check("idle_busy", 64'(busy), 64'h0);

        src_q = '{48'h000001_000002, 48'h000003_000004, 48'h000005_000006, 48'h000007_000008};
        start_frame(4, 1'b0);
        load_words(4, 1'b0, 0);
        wait_done();
        check("busy_after_done", 64'(busy), 64'h0);
        @(posedge clock); #1;

        bad_start(0);
        bad_start(17);
        bad_start($urandom_range(18, 31));

        src_q = '{48'h000010_000005, 48'h7FFFFF_800000};
        start_frame(2, 1'b1);
        load_words(2, 1'b1, 0);
        wait_done();
        @(posedge clock); #1;

        start_frame(16, 1'b0);
        load_words(16, 1'b0, 1);
        bus.in_valid = 1'b1;
        bus.in_data = W'({$urandom(), $urandom()});
        n_valid = 1;
        repeat (3) begin
            @(posedge clock); #1;
            n_valid += int'(bus.out_valid);
        end
        start = 1'b1;
        frame_len = 5'd3;
        @(posedge clock); #1;
        n_valid += int'(bus.out_valid);
        start = 1'b0;
        check("mid_stream_start_no_err", 64'(err), 64'h0);
        check("mid_stream_busy", 64'(busy), 64'h1);
        while (bus.out_valid && n_valid < 40) begin
            @(posedge clock); #1;
            n_valid += int'(bus.out_valid);
        end
        bus.in_valid = 1'b0;
        check("stream_len16", 64'(n_valid), 64'd16);
        wait_done();
        repeat (3) @(posedge clock);
        #1;
        check("ignored_start_idle", 64'(busy), 64'h0);

        start_frame(8, 1'b0);
        load_words(8, 1'b0, 2);
        @(posedge clock); #2;
        reset = 1'b0;
        #1;
        check("async_reset_ctl", {58'h0, busy, done, err, bus.in_ready,
              bus.out_valid, bus.sel_sum_cycle}, 64'h0);
        check("async_reset_yv", 64'(bus.out_YV), 64'h0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        start_frame(1, 1'b0);
        load_words(1, 1'b0, 0);
        wait_done();
        @(posedge clock); #1;

        start = 1'b1;
        frame_len = 5'd3;
        conj_en = 1'b0;
        @(posedge clock); #1;
        load_words(3, 1'b0, 0);
        wait_done();
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b_load_after_done", 64'(bus.in_ready), 64'h1);
        load_words(3, 1'b0, 2);
        wait_done();
        @(posedge clock); #1;

        for (int f = 0; f < 6; f++) begin
            int len;
            bit cj;
            len = $urandom_range(1, 16);
            cj = 1'($urandom_range(0, 1));
            start_frame(len, cj);
            load_words(len, cj, 2);
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        repeat (6) @(posedge clock);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cplx_frame_feeder.md
Name: cplx_frame_feeder

Overview:
- Transmit-side companion of the complex accumulator pipe.
- Buffers one frame of up to DEPTH packed complex samples through a valid/ready load port.
- Replays the frame one word per cycle onto the accumulator's input_YV/sel_sum_cycle interface, with optional conjugation.
- Appends a zero flush so the accumulator's 3-deep input pipe is clean before the next frame.

Parameters:
WIDTH, 48, packed complex word; [WIDTH-1:WIDTH/2] signed real, [WIDTH/2-1:0] signed imag
DEPTH, 16, maximum frame length in words (power of 2)
AW, 4, log2(DEPTH)
FLUSH_LEN, 3, zero words emitted after each frame (matches accumulator input pipe depth)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  frame request; sampled only in IDLE
frame_len  in  AW+1  words in frame, legal 1..DEPTH; sampled with start
conj_en  in  1  negate imag half on replay; sampled with start
in_data  in  WIDTH  load sample
in_valid  in  1  load sample valid
in_ready  out  1  feeder accepts load sample
out_YV  out  WIDTH  sample to accumulator input_YV
out_valid  out  1  out_YV carries a frame word
sel_sum_cycle  out  1  high on first word of each frame (accumulator restart)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of flush
err  out  1  one-cycle pulse on illegal frame_len at start

Behaviour:
- Reset: all outputs 0, state IDLE, write/read pointers 0, buffer contents don't-care. Reset mid-frame aborts immediately; the next frame starts clean.
- Registers: all outputs registered. Buffer is a DEPTH x WIDTH register array.
- IDLE:
  - start with 1<=frame_len<=DEPTH: latch len and conj, wptr=0, go LOAD next cycle.
  - start with frame_len==0 or >DEPTH: err=1 for one cycle, stay IDLE.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid&in_ready: buf[wptr]<=in_data, wptr++.
  - On acceptance of word len-1: in_ready drops the next cycle, rptr=0, go STREAM.
  - in_valid low stalls LOAD indefinitely; no timeout.
- STREAM:
  - Exactly len cycles, no backpressure.
  - out_valid=1, out_YV=buf[rptr] (conjugated if latched conj).
  - sel_sum_cycle=1 on rptr==0 only; rptr++.
  - After word len-1, go FLUSH.
- FLUSH:
  - FLUSH_LEN cycles with out_YV=0, out_valid=0, sel_sum_cycle=0.
  - On the last flush cycle, done=1 the following cycle and state returns to IDLE in that same cycle.
- Latency:
  - First STREAM word appears on the cycle after the last load acceptance.
  - Total frame cost after load is len+FLUSH_LEN cycles, then the done pulse.
- Conjugation: imag' = -imag in two's complement, saturated. Imag of -2^(WIDTH/2-1) maps to 2^(WIDTH/2-1)-1. Real is unchanged.
- Outside STREAM: out_YV=0 and out_valid=0 always.
- start outside IDLE is ignored with no err. start in the same cycle done is asserted is accepted, because state is IDLE then.
- Pointers never wrap within a frame; len==DEPTH fills buf[0..DEPTH-1] exactly.
- in_data presented while in_ready=0 is ignored.

Test Plan:
- Reset, start, frame_len=4, conj_en=0, load 0x000001_000002, 0x000003_000004, 0x000005_000006, 0x000007_000008 back-to-back:
  - in_ready high for 4 cycles.
  - Next 4 cycles out_valid=1 with those words in order; sel_sum_cycle=1 only on the first.
  - Then 3 zero cycles, done pulse, busy=0.
- frame_len=0, then frame_len=17, each with start: err pulses each time, busy stays 0, in_ready stays 0.
- conj_en=1, frame_len=2, words 0x000010_000005 and 0x7FFFFF_800000:
  - Replay is 0x000010_FFFFFB, then 0x7FFFFF_7FFFFF (imag saturates).
- frame_len=16 with in_valid toggling 1,0,1,0:
  - Exactly 16 acceptances, order preserved.
  - STREAM lasts 16 cycles.
  - A start pulse asserted mid-STREAM is ignored.
- Reset asserted on the 2nd STREAM cycle of a len=8 frame:
  - All outputs 0 asynchronously.
  - After release, a new len=1 frame outputs one word with sel_sum_cycle=1, then 3 flush cycles and done.
- Back-to-back frames with start held high:
  - Second frame's LOAD begins on the done cycle.
  - sel_sum_cycle marks the first word of each frame.
  - At least 3 zero cycles separate the frames.
